// File: rtl/bcd_time_base.sv
// ---------------------------------------------------------------------------
// bcd_time_base
//
// Time-keeping core for the digital clock. A prescaler divides clk_1kHz down
// to a once-per-second advance. A BCD hh:mm:ss count is kept with no binary
// intermediate. The per-digit buses feed the hourly chime and the display.
// Hours and minutes can be set, and seconds cleared, through adj_mode and
// the adj_inc key.
//
// Parameters:
//   CLK_FREQ   clk_1kHz cycles per second (prescaler terminal = CLK_FREQ-1)
//   HOUR_MAX   BCD value of the last hour before the wrap to 00
//
// Ports:
//   clk_1kHz    in   system clock
//   rst         in   asynchronous reset, active-high
//   run_en      in   1 = time advances, 0 = prescaler and counters frozen
//   adj_mode    in   00 run, 01 set hours, 10 set minutes, 11 clear seconds
//   adj_inc     in   debounced increment key (level; rising edge used)
//   h_cntH/L    out  hours tens/units (BCD)
//   m_cntH/L    out  minutes tens/units (BCD)
//   s_cntH/L    out  seconds tens/units (BCD)
//   sec_tick    out  one-cycle pulse, coincident with each 1 s advance
//   hour_carry  out  one-cycle pulse when mm:ss wraps 59:59 -> 00:00
//   day_carry   out  one-cycle pulse when HOUR_MAX:59:59 wraps to 00:00:00
//
// All outputs are registered.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_time_base #(
    parameter int         CLK_FREQ = 1000,
    parameter logic [7:0] HOUR_MAX = 8'h23
) (
    input  logic       clk_1kHz,
    input  logic       rst,
    input  logic       run_en,
    input  logic [1:0] adj_mode,
    input  logic       adj_inc,
    output logic [3:0] h_cntH,
    output logic [3:0] h_cntL,
    output logic [3:0] m_cntH,
    output logic [3:0] m_cntL,
    output logic [3:0] s_cntH,
    output logic [3:0] s_cntL,
    output logic       sec_tick,
    output logic       hour_carry,
    output logic       day_carry
);

    localparam int               PRE_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ - 1);

    localparam logic [1:0] MODE_RUN      = 2'b00;
    localparam logic [1:0] MODE_SET_HOUR = 2'b01;
    localparam logic [1:0] MODE_SET_MIN  = 2'b10;
    localparam logic [1:0] MODE_CLR_SEC  = 2'b11;

    // BCD +1 for a 00..59 pair, wrapping 59 -> 00.
    function automatic logic [7:0] bcdInc59(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // BCD +1 for the hour pair, wrapping HOUR_MAX -> 00.
    function automatic logic [7:0] hourInc(input logic [7:0] v);
        logic [7:0] r;
        if (v == HOUR_MAX)        r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    logic [PRE_W-1:0] prescaleCnt;
    logic [PRE_W-1:0] prescaleNext;
    logic             adjIncQ;
    logic             edgeArmed;
    logic             incPulse;
    logic             running;
    logic             secEnd;

    logic [7:0] hours, minutes, seconds;
    logic [7:0] hoursNext, minutesNext, secondsNext;
    logic       secTickNext, hourCarryNext, dayCarryNext;

    assign hours   = {h_cntH, h_cntL};
    assign minutes = {m_cntH, m_cntL};
    assign seconds = {s_cntH, s_cntL};

    // edgeArmed stays low for the first edge after reset so that a key held
    // through reset release is not seen as a fresh press.
    assign incPulse = adj_inc & ~adjIncQ & edgeArmed;
    assign running  = run_en && (adj_mode == MODE_RUN);
    assign secEnd   = running && (prescaleCnt == PRE_MAX);

    always_comb begin
        prescaleNext = prescaleCnt;
        if (adj_mode == MODE_CLR_SEC) begin
            prescaleNext = '0;
        end else if (running) begin
            prescaleNext = secEnd ? '0 : prescaleCnt + 1'b1;
        end
    end

    always_comb begin
        hoursNext     = hours;
        minutesNext   = minutes;
        secondsNext   = seconds;
        secTickNext   = 1'b0;
        hourCarryNext = 1'b0;
        dayCarryNext  = 1'b0;
        case (adj_mode)
            MODE_RUN: begin
                if (secEnd) begin
                    secTickNext = 1'b1;
                    secondsNext = bcdInc59(seconds);
                    if (seconds == 8'h59) begin
                        minutesNext = bcdInc59(minutes);
                        if (minutes == 8'h59) begin
                            hourCarryNext = 1'b1;
                            dayCarryNext  = (hours == HOUR_MAX);
                            hoursNext     = hourInc(hours);
                        end
                    end
                end
            end
            MODE_SET_HOUR: begin
                if (incPulse) hoursNext = hourInc(hours);
            end
            MODE_SET_MIN: begin
                // Setting minutes never ripples into the hours.
                if (incPulse) minutesNext = bcdInc59(minutes);
            end
            MODE_CLR_SEC: begin
                secondsNext = 8'h00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1kHz or posedge rst) begin
        if (rst) begin
            prescaleCnt <= '0;
            adjIncQ     <= 1'b0;
            edgeArmed   <= 1'b0;
            h_cntH      <= '0;
            h_cntL      <= '0;
            m_cntH      <= '0;
            m_cntL      <= '0;
            s_cntH      <= '0;
            s_cntL      <= '0;
            sec_tick    <= 1'b0;
            hour_carry  <= 1'b0;
            day_carry   <= 1'b0;
        end else begin
            prescaleCnt <= prescaleNext;
            adjIncQ     <= adj_inc;
            edgeArmed   <= 1'b1;
            h_cntH      <= hoursNext[7:4];
            h_cntL      <= hoursNext[3:0];
            m_cntH      <= minutesNext[7:4];
            m_cntL      <= minutesNext[3:0];
            s_cntH      <= secondsNext[7:4];
            s_cntL      <= secondsNext[3:0];
            sec_tick    <= secTickNext;
            hour_carry  <= hourCarryNext;
            day_carry   <= dayCarryNext;
        end
    end

endmodule

// File: tb/tb_bcd_time_base.sv
`timescale 1ns/1ps

module tb_bcd_time_base;

    logic       clk;
    logic       rst;
    logic       run_en;
    logic [1:0] adj_mode;
    logic       adj_inc;
    logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
    logic       sec_tick, hour_carry, day_carry;

    int checks = 0;
    int errors = 0;
    int secTicks = 0;
    int hourCarries = 0;
    int dayCarries = 0;
    int snapSec;

    bcd_time_base #(
        .CLK_FREQ (4),
        .HOUR_MAX (8'h23)
    ) dut (
        .clk_1kHz   (clk),
        .rst        (rst),
        .run_en     (run_en),
        .adj_mode   (adj_mode),
        .adj_inc    (adj_inc),
        .h_cntH     (h_cntH),
        .h_cntL     (h_cntL),
        .m_cntH     (m_cntH),
        .m_cntL     (m_cntL),
        .s_cntH     (s_cntH),
        .s_cntL     (s_cntL),
        .sec_tick   (sec_tick),
        .hour_carry (hour_carry),
        .day_carry  (day_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [23:0] timeNow;
    logic [2:0]  pulses;
    assign timeNow = {h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL};
    assign pulses  = {sec_tick, hour_carry, day_carry};

    always @(negedge clk) begin
        if (sec_tick)   secTicks++;
        if (hour_carry) hourCarries++;
        if (day_carry)  dayCarries++;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        adj_inc = 1'b1;
        step(1);
        adj_inc = 1'b0;
        step(1);
    endtask

    // Leaves the prescaler at 0 and the key edge detector armed.
    task automatic doReset();
        adj_inc  = 1'b0;
        adj_mode = 2'b11;
        rst      = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst      = 1'b1;
        run_en   = 1'b0;
        adj_mode = 2'b00;
        adj_inc  = 1'b0;
        step(2);
        checkVal("rst_time", timeNow, 24'h000000);
        checkVal("rst_pulses", pulses, 3'b000);
        checkVal("rst_prescale", dut.prescaleCnt, 0);

        // 1: run from reset
        rst    = 1'b0;
        run_en = 1'b1;
        step(3);
        checkVal("t1_no_tick_yet", sec_tick, 1'b0);
        checkVal("t1_time_early", timeNow, 24'h000000);
        step(1);
        checkVal("t1_first_tick", sec_tick, 1'b1);
        checkVal("t1_time_1s", timeNow, 24'h000001);
        step(1);
        checkVal("t1_tick_width", sec_tick, 1'b0);
        step(35);
        checkVal("t1_time_10s", timeNow, 24'h000010);

        // 2: 00:59:58 -> 01:00:00
        doReset();
        adj_mode = 2'b10;
        repeat (59) pulse();
        checkVal("t2_set_min", timeNow, 24'h005900);
        adj_mode = 2'b00;
        step(232);
        checkVal("t2_preload", timeNow, 24'h005958);
        step(4);
        checkVal("t2_5959", timeNow, 24'h005959);
        checkVal("t2_no_carry", pulses, 3'b100);
        step(4);
        checkVal("t2_hour_wrap", timeNow, 24'h010000);
        checkVal("t2_pulses", pulses, 3'b110);
        step(1);
        checkVal("t2_pulses_gone", pulses, 3'b000);

        // 3: 23:59:59 -> 00:00:00
        doReset();
        adj_mode = 2'b01;
        repeat (23) pulse();
        checkVal("t3_set_hour", timeNow, 24'h230000);
        adj_mode = 2'b10;
        repeat (59) pulse();
        adj_mode = 2'b00;
        step(236);
        checkVal("t3_235959", timeNow, 24'h235959);
        step(4);
        checkVal("t3_day_wrap", timeNow, 24'h000000);
        checkVal("t3_pulses", pulses, 3'b111);
        step(1);
        checkVal("t3_pulses_gone", pulses, 3'b000);

        // 4: minute set does not carry; held key increments once
        doReset();
        adj_mode = 2'b01;
        repeat (36) pulse();
        checkVal("t4_hour_set_wrap", timeNow, 24'h120000);
        adj_mode = 2'b10;
        repeat (59) pulse();
        adj_mode = 2'b00;
        step(120);
        checkVal("t4_preload", timeNow, 24'h125930);
        adj_mode = 2'b10;
        step(1);
        snapSec = secTicks;
        pulse();
        checkVal("t4_min_wrap", timeNow, 24'h120030);
        adj_inc = 1'b1;
        step(20);
        adj_inc = 1'b0;
        step(1);
        checkVal("t4_held_key", timeNow, 24'h120130);
        step(1);
        checkVal("t4_no_sec_tick", secTicks, snapSec);
        checkVal("t4_hour_carries", hourCarries, 2);
        checkVal("t4_day_carries", dayCarries, 1);

        // 5: clear seconds mid-count
        doReset();
        adj_mode = 2'b01;
        repeat (5) pulse();
        adj_mode = 2'b10;
        repeat (17) pulse();
        adj_mode = 2'b00;
        step(168);
        checkVal("t5_preload", timeNow, 24'h051742);
        step(2);
        checkVal("t5_prescale_mid", dut.prescaleCnt, 2);
        adj_mode = 2'b11;
        step(1);
        checkVal("t5_sec_cleared", timeNow, 24'h051700);
        checkVal("t5_prescale_zero", dut.prescaleCnt, 0);
        pulse();
        checkVal("t5_inc_ignored", timeNow, 24'h051700);
        adj_mode = 2'b00;
        step(3);
        checkVal("t5_no_early_tick", sec_tick, 1'b0);
        step(1);
        checkVal("t5_tick", sec_tick, 1'b1);
        checkVal("t5_time", timeNow, 24'h051701);

        // 6: freeze, then async reset
        step(2);
        snapSec = secTicks;
        run_en = 1'b0;
        step(10);
        checkVal("t6_frozen_time", timeNow, 24'h051701);
        checkVal("t6_frozen_prescale", dut.prescaleCnt, 2);
        checkVal("t6_frozen_ticks", secTicks, snapSec);
        run_en = 1'b1;
        step(2);
        checkVal("t6_resume_tick", sec_tick, 1'b1);
        checkVal("t6_resume_time", timeNow, 24'h051702);
        #2;
        rst = 1'b1;
        #1;
        checkVal("t6_async_time", timeNow, 24'h000000);
        checkVal("t6_async_pulses", pulses, 3'b000);
        checkVal("t6_async_prescale", dut.prescaleCnt, 0);
        step(1);
        adj_mode = 2'b01;
        adj_inc  = 1'b1;
        rst      = 1'b0;
        step(1);
        checkVal("t6_no_pulse_after_rst", pulses, 3'b000);
        step(3);
        checkVal("t6_held_key_no_inc", timeNow, 24'h000000);
        adj_inc = 1'b0;
        step(1);
        adj_inc = 1'b1;
        step(1);
        checkVal("t6_fresh_press", timeNow, 24'h010000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
